uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  UART receiver; counterpart to the team's uart_tx. 8N1 frames, LSB first, 50 MHz clk.
//  Same 4-bit baud-select table as uart_tx.
//  Samples RX at mid-bit, delivers one byte per frame with a 1-cycle rx_done strobe.
//  Sits between the robot's serial pin and the command decoder.
// PARAMETERS
//  SYNC_STAGES  2   RX metastability flops (min 2)
//  DIV_W        14  width of bit-period counter
// PORTS
//  clk            in   1  system clock, 50 MHz
//  rst_n          in   1  reset, asynchronous, active-low
//  set_Baud_rate  in   4  0:9600 1:19200 2:38400 3:57600 4:115200, other:9600
//  en             in   1  receive enable
//  RX             in   1  serial input, idle high, asynchronous to clk
//  data           out  8  last good byte; held until next good frame
//  rx_done        out  1  1-cycle pulse: data just updated
//  frame_err      out  1  1-cycle pulse: stop bit sampled low
//  busy           out  1  high from start detect until return to IDLE
// BEHAVIOUR
//  Reset: data=0, rx_done=0, frame_err=0, busy=0, state=IDLE, sync flops=1.
//  Divider DIV from select: 5207/2603/1301/867/433, 5207 otherwise.
//   - One bit period = DIV+1 clocks.
//   - DIV is latched on start detect; select changes mid-frame are ignored.
//  rx_s = RX after SYNC_STAGES flops. Falling edge = previous rx_s 1, current rx_s 0.
//  FSM:
//   IDLE:
//    - on en && falling edge of rx_s: -> START, cnt=0, busy=1.
//   START:
//    - at cnt==DIV>>1: if rx_s==1 (glitch) -> IDLE with no pulse; else -> DATA, cnt=0, bit=0.
//   DATA:
//    - at cnt==DIV: shift rx_s into shreg[bit], cnt=0, bit++.
//    - after bit 7: -> STOP.
//   STOP:
//    - at cnt==DIV: if rx_s==1, data<=shreg and rx_done=1; else frame_err=1 and data unchanged.
//    - Then -> IDLE, busy=0.
//  Sample points are mid-bit. Stop is left at its midpoint, so back-to-back frames are accepted.
//  Latency: rx_done is ~9.5 bit periods + SYNC_STAGES + 1 clocks after the RX falling edge.
//  rx_done and frame_err are never high together. Each is high for exactly 1 clock.
//  en low:
//   - state forced to IDLE in the next clock; cnt, bit and busy cleared.
//   - no pulses; data retained.
//  RX held low in IDLE (break): no new start until rx_s has been seen high again.
//   A frame ending in frame_err with RX still low therefore does not retrigger.
//  Reset asserted mid-frame: immediate return to reset values; no pulse on release.
//  cnt never exceeds DIV; bit index 0..7, no wrap beyond 7.
// STRUCTURE
//  Shared package uart_pkg:
//   - baud divider table as localparams: BAUD_DIV_9600 = 5207 ... BAUD_DIV_115200 = 433.
//   - function baud_div(sel) -> DIV, used by uart_tx and uart_rx.
//   - FSM state encoding localparams: ST_IDLE, ST_START, ST_DATA, ST_STOP.
//  One sub-module: uart_sync (parameterised N-flop synchronizer, reset value 1).
//  Rest is flat: divider latch, bit counter, shift register, FSM, output regs.
// TESTING
//  1. sel=0, en=1, send 0x55 at 9600 -> one rx_done, data=0x55, ~49,480 clks after start edge.
//  2. sel=4, send 0xA3 then 0x3C back-to-back at 115200 -> two rx_done, data 0xA3 then 0x3C.
//  3. RX low for 100 clks then high (sel=4) -> no rx_done/frame_err; busy high ~217 clks then 0.
//  4. sel=4, 0x81 with stop bit forced low -> frame_err 1 clk, rx_done 0, data keeps previous.
//  5. Reset during bit 4 of 0xF0 -> all outputs 0 immediately; next clean 0x0F received correctly.
//  6. en dropped during bit 3 -> busy=0 next clk, no pulses.
//     Also: sel changed 0->4 mid-frame -> frame still decoded at 9600.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the team's UART blocks (uart_tx and uart_rx).
//  - Baud divider table for a 50 MHz clock. One bit period is DIV+1 clocks.
//  - baud_div(): maps the 4-bit baud select code to its divider.
//  - Receiver FSM state encoding.
// No ports; import with "import uart_pkg::*;".
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int BAUD_DIV_9600   = 5207;
  localparam int BAUD_DIV_19200  = 2603;
  localparam int BAUD_DIV_38400  = 1301;
  localparam int BAUD_DIV_57600  = 867;
  localparam int BAUD_DIV_115200 = 433;

  localparam int BAUD_DIV_W = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // Unused select codes fall back to 9600 so a miswired select still
  // produces a slow but usable link.
  function automatic logic [BAUD_DIV_W-1:0] baud_div(input logic [3:0] sel);
    logic [BAUD_DIV_W-1:0] div;
    case (sel)
      4'd1:    div = BAUD_DIV_W'(BAUD_DIV_19200);
      4'd2:    div = BAUD_DIV_W'(BAUD_DIV_38400);
      4'd3:    div = BAUD_DIV_W'(BAUD_DIV_57600);
      4'd4:    div = BAUD_DIV_W'(BAUD_DIV_115200);
      default: div = BAUD_DIV_W'(BAUD_DIV_9600);
    endcase
    return div;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if
// Signal bundle between the serial pin side / command decoder and uart_rx.
//  set_Baud_rate  4  baud select code (see uart_pkg::baud_div)
//  en             1  receive enable
//  RX             1  serial input, idle high, asynchronous to clk
//  data           8  last good byte, held until the next good frame
//  rx_done        1  1-clock pulse: data was just updated
//  frame_err      1  1-clock pulse: stop bit sampled low
//  busy           1  high while a frame is being received
// master drives the controls and RX; slave is the receiver.
// ---------------------------------------------------------------------------
interface uart_rx_if;

  logic [3:0] set_Baud_rate;
  logic       en;
  logic       RX;
  logic [7:0] data;
  logic       rx_done;
  logic       frame_err;
  logic       busy;

  modport master (
    output set_Baud_rate, en, RX,
    input  data, rx_done, frame_err, busy
  );

  modport slave (
    input  set_Baud_rate, en, RX,
    output data, rx_done, frame_err, busy
  );

endinterface

// File: rtl/uart_sync.sv
// ---------------------------------------------------------------------------
// uart_sync
// N-flop synchronizer for an asynchronous serial line. Resets to 1 so an
// idle-high line never looks like a start bit straight out of reset.
//  clk    in  system clock
//  rst_n  in  asynchronous active-low reset
//  d_i    in  asynchronous input
//  q_o    out synchronized output, N clocks behind d_i
// N must be at least 2.
// ---------------------------------------------------------------------------
module uart_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] sync_q;

  // Shift chain; only the last stage is used by the receiver.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
    end
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver, LSB first, 50 MHz clock. Detects the start edge,
// samples every bit at its midpoint and delivers one byte per frame.
//  clk    in   system clock, 50 MHz
//  rst_n  in   asynchronous active-low reset
//  rx_if  slave modport of uart_rx_if (controls, RX, data and status)
// Parameters:
//  SYNC_STAGES  RX metastability flops (min 2)
//  DIV_W        width of the bit-period counter
// ---------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DIV_W       = 14
) (
  input  logic      clk,
  input  logic      rst_n,
  uart_rx_if.slave  rx_if
);

  logic              rxS;
  logic              rxPrev_q;
  logic              fallEdge;

  uart_state_e       state_q,    state_d;
  logic [DIV_W-1:0]  cnt_q,      cnt_d;
  logic [DIV_W-1:0]  div_q,      div_d;
  logic [2:0]        bitIdx_q,   bitIdx_d;
  logic [7:0]        shReg_q,    shReg_d;
  logic [7:0]        data_q,     data_d;
  logic              rxDone_q,   rxDone_d;
  logic              frameErr_q, frameErr_d;

  uart_sync #(.N(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx_if.RX),
    .q_o   (rxS)
  );

  // The previous sample tracks the line in every state, so a line that went
  // low while a frame was in progress (or held low as a break) must be seen
  // high again before the next start edge can be detected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxPrev_q <= 1'b1;
    end else begin
      rxPrev_q <= rxS;
    end
  end

  assign fallEdge = rxPrev_q & ~rxS;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      div_q      <= DIV_W'(BAUD_DIV_9600);
      bitIdx_q   <= '0;
      shReg_q    <= '0;
      data_q     <= '0;
      rxDone_q   <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      bitIdx_q   <= bitIdx_d;
      shReg_q    <= shReg_d;
      data_q     <= data_d;
      rxDone_q   <= rxDone_d;
      frameErr_q <= frameErr_d;
    end
  end

  // Next-state logic. The divider is captured on the start edge so the
  // baud select may change freely while a frame is in flight. START waits
  // half a bit period to land on the middle of the start bit; every later
  // sample is one full period further on. STOP returns to IDLE at the stop
  // bit's midpoint so a back-to-back start edge is not missed.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    bitIdx_d   = bitIdx_q;
    shReg_d    = shReg_q;
    data_d     = data_q;
    rxDone_d   = 1'b0;
    frameErr_d = 1'b0;

    if (!rx_if.en) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      bitIdx_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fallEdge) begin
            state_d  = ST_START;
            cnt_d    = '0;
            bitIdx_d = '0;
            div_d    = DIV_W'(baud_div(rx_if.set_Baud_rate));
          end
        end

        ST_START: begin
          if (cnt_q == (div_q >> 1)) begin
            cnt_d = '0;
            if (rxS) begin
              state_d = ST_IDLE;
            end else begin
              state_d  = ST_DATA;
              bitIdx_d = '0;
            end
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
          end
        end

        ST_DATA: begin
          if (cnt_q == div_q) begin
            shReg_d[bitIdx_q] = rxS;
            cnt_d             = '0;
            if (bitIdx_q == 3'd7) begin
              state_d = ST_STOP;
            end else begin
              bitIdx_d = bitIdx_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
          end
        end

        ST_STOP: begin
          if (cnt_q == div_q) begin
            if (rxS) begin
              data_d   = shReg_q;
              rxDone_d = 1'b1;
            end else begin
              frameErr_d = 1'b1;
            end
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
          end
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign rx_if.data      = data_q;
  assign rx_if.rx_done   = rxDone_q;
  assign rx_if.frame_err = frameErr_q;
  assign rx_if.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx: drives serial frames bit by bit and checks
// received bytes, strobes, busy timing, break, reset and enable behaviour.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int P9600 = 5208;
  localparam int P115  = 434;

  logic clk = 1'b0;
  logic rst_n;

  always #10 clk = ~clk;

  uart_rx_if busIf();

  uart_rx #(.SYNC_STAGES(2), .DIV_W(14)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx_if (busIf)
  );

  int errors = 0;
  int checks = 0;
  int cycleCount = 0;
  int doneCount = 0;
  int errCount = 0;
  int busyCount = 0;
  int bothCount = 0;
  int lastDoneCycle = 0;
  logic [7:0] doneLog [0:15];

  // Free-running clock counter used for latency measurement.
  always @(posedge clk) cycleCount++;

  // Records every strobe cycle and captured byte, sampled on the falling edge.
  always @(negedge clk) begin
    if (busIf.rx_done === 1'b1) begin
      if (doneCount < 16) doneLog[doneCount] = busIf.data;
      doneCount++;
      lastDoneCycle = cycleCount;
    end
    if (busIf.frame_err === 1'b1) errCount++;
    if (busIf.busy === 1'b1) busyCount++;
    if (busIf.rx_done === 1'b1 && busIf.frame_err === 1'b1) bothCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic driveBit(input logic v, input int cycles);
    busIf.RX = v;
    repeat (cycles) @(negedge clk);
  endtask

  // Frame bit index: 0 = start, 1..8 = data LSB first, 9 = stop.
  task automatic applyStimulus(input logic [7:0] b, input logic stopBit,
                               input int period, input int firstIdx, input int lastIdx);
    for (int i = firstIdx; i <= lastIdx; i++) begin
      logic v;
      if (i == 0)      v = 1'b0;
      else if (i == 9) v = stopBit;
      else             v = b[i-1];
      driveBit(v, period);
    end
  endtask

  int baseDone, baseErr, baseBusy, startCycle, latency;

  initial begin
    busIf.RX            = 1'b1;
    busIf.en            = 1'b0;
    busIf.set_Baud_rate = 4'd0;
    rst_n               = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("reset_data",      32'(busIf.data),      32'h0);
    checkOutput("reset_rx_done",   32'(busIf.rx_done),   32'h0);
    checkOutput("reset_frame_err", 32'(busIf.frame_err), 32'h0);
    checkOutput("reset_busy",      32'(busIf.busy),      32'h0);

    rst_n    = 1'b1;
    busIf.en = 1'b1;
    repeat (5) @(negedge clk);

    // 0x55 at 9600; select moved to 115200 after the start bit.
    $display("[TB] 0x55 at 9600 with select change mid-frame");
    baseDone   = doneCount;
    baseErr    = errCount;
    startCycle = cycleCount;
    driveBit(1'b0, P9600);
    busIf.set_Baud_rate = 4'd4;
    applyStimulus(8'h55, 1'b1, P9600, 1, 9);
    driveBit(1'b1, 200);
    latency = lastDoneCycle - startCycle;
    checkOutput("t1_done_count", 32'(doneCount - baseDone), 32'd1);
    checkOutput("t1_log_byte",   32'(doneLog[baseDone]),    32'h55);
    checkOutput("t1_data",       32'(busIf.data),           32'h55);
    checkOutput("t1_no_err",     32'(errCount - baseErr),   32'd0);
    checkOutput("t1_latency_in_window",
                32'(latency >= 49470 && latency <= 49490), 32'd1);

    // Back-to-back frames at 115200.
    $display("[TB] 0xA3 then 0x3C back-to-back at 115200");
    baseDone = doneCount;
    baseErr  = errCount;
    applyStimulus(8'hA3, 1'b1, P115, 0, 9);
    applyStimulus(8'h3C, 1'b1, P115, 0, 9);
    driveBit(1'b1, 300);
    checkOutput("t2_done_count", 32'(doneCount - baseDone), 32'd2);
    checkOutput("t2_first",      32'(doneLog[baseDone]),     32'hA3);
    checkOutput("t2_second",     32'(doneLog[baseDone + 1]), 32'h3C);
    checkOutput("t2_no_err",     32'(errCount - baseErr),    32'd0);

    // Short low glitch: START rejects it at the half-bit point (DIV>>1 + 1 = 217 clocks).
    $display("[TB] glitch of 100 clocks at 115200");
    baseDone = doneCount;
    baseErr  = errCount;
    baseBusy = busyCount;
    driveBit(1'b0, 100);
    driveBit(1'b1, 400);
    checkOutput("t3_busy_cycles", 32'(busyCount - baseBusy), 32'd217);
    checkOutput("t3_no_done",     32'(doneCount - baseDone), 32'd0);
    checkOutput("t3_no_err",      32'(errCount - baseErr),   32'd0);

    // Stop bit low, line then held low: one frame error, no retrigger.
    $display("[TB] 0x81 with low stop bit then break");
    baseDone = doneCount;
    baseErr  = errCount;
    applyStimulus(8'h81, 1'b0, P115, 0, 9);
    driveBit(1'b0, 500);
    checkOutput("t4_err_cycles",  32'(errCount - baseErr),   32'd1);
    checkOutput("t4_no_done",     32'(doneCount - baseDone), 32'd0);
    checkOutput("t4_data_kept",   32'(busIf.data),           32'h3C);
    checkOutput("t4_no_retrigger", 32'(busIf.busy),          32'h0);
    driveBit(1'b1, 100);

    // Reset during data bit 4 of 0xF0, then a clean 0x0F.
    $display("[TB] reset mid-frame then 0x0F");
    applyStimulus(8'hF0, 1'b1, P115, 0, 4);
    driveBit(1'b1, 200);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_data",      32'(busIf.data),      32'h0);
    checkOutput("t5_rst_rx_done",   32'(busIf.rx_done),   32'h0);
    checkOutput("t5_rst_frame_err", 32'(busIf.frame_err), 32'h0);
    checkOutput("t5_rst_busy",      32'(busIf.busy),      32'h0);
    baseDone = doneCount;
    baseErr  = errCount;
    @(negedge clk);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    driveBit(1'b1, 600);
    checkOutput("t5_no_pulse_after_release",
                32'((doneCount - baseDone) + (errCount - baseErr)), 32'd0);
    baseDone = doneCount;
    applyStimulus(8'h0F, 1'b1, P115, 0, 9);
    driveBit(1'b1, 300);
    checkOutput("t5_done_count", 32'(doneCount - baseDone), 32'd1);
    checkOutput("t5_data",       32'(busIf.data),           32'h0F);

    // Enable dropped during data bit 3 of 0x96 (bit 3 is 0).
    $display("[TB] enable dropped mid-frame");
    baseDone = doneCount;
    baseErr  = errCount;
    applyStimulus(8'h96, 1'b1, P115, 0, 3);
    driveBit(1'b0, 200);
    checkOutput("t6_busy_before_drop", 32'(busIf.busy), 32'h1);
    busIf.en = 1'b0;
    @(negedge clk);
    checkOutput("t6_busy_after_drop", 32'(busIf.busy), 32'h0);
    driveBit(1'b0, 233);
    applyStimulus(8'h96, 1'b1, P115, 5, 9);
    driveBit(1'b1, 100);
    checkOutput("t6_no_done",   32'(doneCount - baseDone), 32'd0);
    checkOutput("t6_no_err",    32'(errCount - baseErr),   32'd0);
    checkOutput("t6_data_kept", 32'(busIf.data),           32'h0F);

    busIf.en = 1'b1;
    driveBit(1'b1, 20);
    baseDone = doneCount;
    applyStimulus(8'hC5, 1'b1, P115, 0, 9);
    driveBit(1'b1, 300);
    checkOutput("t6_recover_done", 32'(doneCount - baseDone), 32'd1);
    checkOutput("t6_recover_data", 32'(busIf.data),           32'hC5);

    checkOutput("never_both_strobes", 32'(bothCount), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
